sram_bank_mem_adapter: RTL and testbench

Parametrised bridge between the picorv32 native memory interface (mem_valid/mem_ready) and one or more sky130 1rw SRAM macro banks. It replaces the fixed single-bank, one-cycle-echo memory hookup used in the SoC wrappers:
- proper single-pulse mem_ready handshake;
- configurable bank count, depth and macro read latency;
- address-range decode across banks;
- sticky error reporting for out-of-range accesses.

It sits between the core instance and the SRAM macros inside the SoC top.

---
 rtl/sram_bank_mem_adapter_if.sv | 35 +++
 rtl/sram_bank_mem_adapter.sv | 158 +++++++++++++++
 tb/tb_sram_bank_mem_adapter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bank_mem_adapter_if.sv
// rtl/sram_bank_mem_adapter_if.sv - picorv32 native bus plus SRAM bank bus bundle
// master = core/macro side, slave = adapter side.
interface sram_bank_mem_adapter_if #(
  parameter int BANKS = 2,
  parameter int WAW   = 9
);
  logic                  mem_valid;
  logic                  mem_instr;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;
  logic [BANKS-1:0]      sram_csb;
  logic                  sram_web;
  logic [3:0]            sram_wmask;
  logic [WAW-1:0]        sram_addr;
  logic [31:0]           sram_din;
  logic [BANKS*32-1:0]   sram_dout;
  logic                  err;
  logic [31:0]           err_addr;
  logic                  err_clr;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, sram_dout, err_clr,
    input  mem_ready, mem_rdata, sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
           err, err_addr
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, sram_dout, err_clr,
    output mem_ready, mem_rdata, sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
           err, err_addr
  );
endinterface

// File: rtl/sram_bank_mem_adapter.sv
// rtl/sram_bank_mem_adapter.sv - picorv32 mem_valid/mem_ready bridge to banked 1rw SRAM macros
// Contiguous bank decode, configurable macro read latency, sticky out-of-range error capture.
module sram_bank_mem_adapter #(
  parameter int          BANKS        = 2,
  parameter int          BANK_WORDS   = 512,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input logic                clk,
  input logic                reset,
  sram_bank_mem_adapter_if.slave bus
);

  localparam int WAW = $clog2(BANK_WORDS);
  localparam int BAW = (BANKS > 1) ? $clog2(BANKS) : 0;
  localparam int BW  = (BAW > 0) ? BAW : 1;
  localparam int CW  = $clog2(READ_LATENCY + 1);
  localparam logic [32:0] SPAN = 33'(BANKS) * 33'(BANK_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bank_q, bank_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [BANKS-1:0] csb_q, csb_d;
  logic             web_q, web_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [WAW-1:0]   addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic [31:0]      off;
  logic             in_range;
  logic [BW-1:0]    dec_bank;
  logic [WAW-1:0]   dec_word;

  always_comb begin
    off        = bus.mem_addr - BASE_ADDR;
    in_range   = {1'b0, off} < SPAN;
    dec_bank   = BW'(off >> (WAW + 2));
    dec_word   = WAW'(off >> 2);

    state_d    = state_q;
    bank_d     = bank_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    csb_d      = '1;
    web_d      = 1'b1;
    wmask_d    = wmask_q;
    addr_d     = addr_q;
    din_d      = din_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    // Macro strobes are set up on the IDLE->ACCESS edge so they are live exactly while in ACCESS.
    case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          if (in_range) begin
            bank_d  = dec_bank;
            addr_d  = dec_word;
            din_d   = bus.mem_wdata;
            wmask_d = bus.mem_wstrb;
            csb_d   = ~(BANKS'(1) << dec_bank);
            web_d   = (bus.mem_wstrb == 4'd0);
            state_d = ACCESS;
          end else begin
            if (bus.mem_wstrb == 4'd0) begin
              rdata_d = ERR_DATA;
            end
            if (!err_q) begin
              err_d      = 1'b1;
              err_addr_d = bus.mem_addr;
            end
            ready_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (wmask_q != 4'd0) begin
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = CW'(READ_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          rdata_d = bus.sram_dout[{bank_q, 5'b0} +: 32];
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A clear wins over an error raised in the same cycle.
    if (bus.err_clr) begin
      err_d      = 1'b0;
      err_addr_d = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bank_q     <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      csb_q      <= '1;
      web_q      <= 1'b1;
      wmask_q    <= 4'd0;
      addr_q     <= '0;
      din_q      <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      wmask_q    <= wmask_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.mem_ready  = ready_q;
  assign bus.mem_rdata  = rdata_q;
  assign bus.sram_csb   = csb_q;
  assign bus.sram_web   = web_q;
  assign bus.sram_wmask = wmask_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_din   = din_q;
  assign bus.err        = err_q;
  assign bus.err_addr   = err_addr_q;

endmodule

// File: tb/tb_sram_bank_mem_adapter.sv
// tb/tb_sram_bank_mem_adapter.sv - directed scoreboard bench for sram_bank_mem_adapter
// Two builds: 2x512 banks with latency 1, and 1x16 bank with latency 3.
module tb_sram_bank_mem_adapter;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_bank_mem_adapter_if #(.BANKS(2), .WAW(9)) bus1();
  sram_bank_mem_adapter_if #(.BANKS(1), .WAW(4)) bus3();

  sram_bank_mem_adapter #(
    .BANKS(2), .BANK_WORDS(512), .READ_LATENCY(1),
    .BASE_ADDR(BASE), .ERR_DATA(32'hDEAD_BEEF)
  ) u_dut (.clk(clk), .reset(reset), .bus(bus1.slave));

  sram_bank_mem_adapter #(
    .BANKS(1), .BANK_WORDS(16), .READ_LATENCY(3),
    .BASE_ADDR(32'h0), .ERR_DATA(32'hDEAD_BEEF)
  ) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  logic        t_valid = 1'b0, t_sel = 1'b0, t_clr = 1'b0;
  logic [31:0] t_addr = 32'd0, t_wdata = 32'd0;
  logic [3:0]  t_wstrb = 4'd0;

  assign bus1.mem_valid = t_valid & ~t_sel;
  assign bus3.mem_valid = t_valid & t_sel;
  assign bus1.mem_instr = 1'b0;
  assign bus3.mem_instr = 1'b0;
  assign bus1.mem_addr  = t_addr;
  assign bus3.mem_addr  = t_addr;
  assign bus1.mem_wdata = t_wdata;
  assign bus3.mem_wdata = t_wdata;
  assign bus1.mem_wstrb = t_wstrb;
  assign bus3.mem_wstrb = t_wstrb;
  assign bus1.err_clr   = t_clr;
  assign bus3.err_clr   = 1'b0;

  wire        rdy      = t_sel ? bus3.mem_ready : bus1.mem_ready;
  wire [31:0] rdy_data = t_sel ? bus3.mem_rdata : bus1.mem_rdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  // SRAM macro models
  logic [31:0] m1 [2][512];
  logic [31:0] d1 [2];
  assign bus1.sram_dout = {d1[1], d1[0]};
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!bus1.sram_csb[b]) begin
        if (!bus1.sram_web)
          m1[b][bus1.sram_addr] <= merge(m1[b][bus1.sram_addr], bus1.sram_din, bus1.sram_wmask);
        else
          d1[b] <= m1[b][bus1.sram_addr];
      end
    end
  end

  logic [31:0] m3 [16];
  logic [31:0] p3 [3];
  assign bus3.sram_dout = p3[2];
  always @(posedge clk) begin
    if (!bus3.sram_csb[0]) begin
      if (!bus3.sram_web)
        m3[bus3.sram_addr] <= merge(m3[bus3.sram_addr], bus3.sram_din, bus3.sram_wmask);
      else
        p3[0] <= m3[bus3.sram_addr];
    end
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  // Activity monitors
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rdy1_cnt = 0, rdy3_cnt = 0, csb1_cnt = 0, csb3_cnt = 0;
  int snap_cyc = 0;
  logic [1:0]  snap_csb = 2'b11;
  logic        snap_web = 1'b1;
  logic [8:0]  snap_addr = '0;
  logic [3:0]  snap_wmask = '0;
  logic [31:0] snap_din = '0;
  always @(negedge clk) begin
    if (bus1.mem_ready) rdy1_cnt <= rdy1_cnt + 1;
    if (bus3.mem_ready) rdy3_cnt <= rdy3_cnt + 1;
    if (bus3.sram_csb != 1'b1) csb3_cnt <= csb3_cnt + 1;
    if (bus1.sram_csb != 2'b11) begin
      csb1_cnt   <= csb1_cnt + 1;
      snap_cyc   <= cyc;
      snap_csb   <= bus1.sram_csb;
      snap_web   <= bus1.sram_web;
      snap_addr  <= bus1.sram_addr;
      snap_wmask <= bus1.sram_wmask;
      snap_din   <= bus1.sram_din;
    end
  end

  int n_vec = 0, n_err = 0;
  int exp_rdy = 0, exp_csb = 0, req_start = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    int          lat;
    bit          chk_rd;
  } sb_t;
  sb_t sb[$];

  logic [31:0] ref1 [1024];
  logic [31:0] ref3 [16];

  // Called at posedge+1: issues one request, waits for the ready pulse, drops valid the cycle after.
  task automatic req(input bit sel, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int exp_lat, input logic [31:0] exp_rd, input bit chk_rd, input string tag);
    int lat;
    logic [31:0] got;
    sb_t e;
    sb.push_back('{exp_rd, exp_lat, chk_rd});
    exp_rdy++;
    if (exp_lat > 1) exp_csb++;
    req_start = cyc;
    t_sel = sel; t_addr = a; t_wdata = d; t_wstrb = s; t_valid = 1'b1;
    lat = -1;
    got = 32'd0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rdy) begin
        lat = c;
        got = rdy_data;
        break;
      end
    end
    @(posedge clk);
    #1;
    t_valid = 1'b0; t_wstrb = 4'd0;
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    if (e.chk_rd) chk({tag, "_rdata"}, got, e.rd);
  endtask

  task automatic wr(input bit sel, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
    int i;
    if (sel) begin
      i = int'(a[5:2]);
      ref3[i] = merge(ref3[i], d, s);
      req(1'b1, a, d, s, 2, 32'd0, 1'b0, tag);
    end else begin
      i = int'((a - BASE) >> 2);
      ref1[i] = merge(ref1[i], d, s);
      req(1'b0, a, d, s, 2, 32'd0, 1'b0, tag);
    end
  endtask

  task automatic rd(input bit sel, input logic [31:0] a, input string tag);
    if (sel) req(1'b1, a, 32'd0, 4'd0, 5, ref3[int'(a[5:2])], 1'b1, tag);
    else     req(1'b0, a, 32'd0, 4'd0, 3, ref1[int'((a - BASE) >> 2)], 1'b1, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst_csb", 32'(bus1.sram_csb), 32'h3);
    chk("rst_web", 32'(bus1.sram_web), 32'h1);
    chk("rst_ready", 32'(bus1.mem_ready), 32'h0);
    chk("rst_rdata", bus1.mem_rdata, 32'h0);
    chk("rst_wmask", 32'(bus1.sram_wmask), 32'h0);
    chk("rst_addr", 32'(bus1.sram_addr), 32'h0);
    chk("rst_din", bus1.sram_din, 32'h0);
    chk("rst_err", {31'd0, bus1.err}, 32'h0);
    chk("rst_err_addr", bus1.err_addr, 32'h0);
    chk("rst_csb3", 32'(bus3.sram_csb), 32'h1);
    reset = 1'b0;
    tick();

    wr(1'b0, BASE + 32'h4, 32'h1234_5678, 4'hF, "wr_b4");
    chk("wr_b4_csb_cycle", 32'(snap_cyc - req_start), 32'd1);
    chk("wr_b4_csb", 32'(snap_csb), 32'h2);
    chk("wr_b4_web", 32'(snap_web), 32'h0);
    chk("wr_b4_addr", 32'(snap_addr), 32'd1);
    chk("wr_b4_wmask", 32'(snap_wmask), 32'hF);
    chk("wr_b4_din", snap_din, 32'h1234_5678);
    rd(1'b0, BASE + 32'h4, "rd_b4");
    chk("rd_b4_web", 32'(snap_web), 32'h1);

    wr(1'b0, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, "wr_full");
    wr(1'b0, BASE + 32'h8, 32'h0000_AB00, 4'b0010, "wr_part");
    chk("part_ref", ref1[2], 32'hFFFF_ABFF);
    rd(1'b0, BASE + 32'h8, "rd_part");

    wr(1'b0, BASE + 32'h800, 32'hA5A5_0001, 4'hF, "wr_bank1");
    chk("bank1_csb", 32'(snap_csb), 32'h1);
    chk("bank1_addr", 32'(snap_addr), 32'd0);
    wr(1'b0, BASE + 32'h7FC, 32'h5A5A_01FF, 4'hF, "wr_top0");
    chk("top0_csb", 32'(snap_csb), 32'h2);
    chk("top0_addr", 32'(snap_addr), 32'd511);
    rd(1'b0, BASE + 32'h800, "rd_bank1");
    rd(1'b0, BASE + 32'h7FC, "rd_top0");

    req(1'b0, BASE + 32'h1000, 32'd0, 4'd0, 1, 32'hDEAD_BEEF, 1'b1, "oor_rd");
    chk("oor_err", {31'd0, bus1.err}, 32'h1);
    chk("oor_err_addr", bus1.err_addr, BASE + 32'h1000);
    req(1'b0, BASE - 32'h4, 32'h1111_1111, 4'hF, 1, 32'd0, 1'b0, "oor_wr");
    chk("oor2_err_addr", bus1.err_addr, BASE + 32'h1000);
    t_clr = 1'b1; tick(); t_clr = 1'b0;
    chk("clr_err", {31'd0, bus1.err}, 32'h0);
    chk("clr_err_addr", bus1.err_addr, 32'h0);
    t_clr = 1'b1;
    req(1'b0, BASE + 32'h2000, 32'd0, 4'd0, 1, 32'hDEAD_BEEF, 1'b1, "oor_clr");
    t_clr = 1'b0;
    chk("clr_prio_err", {31'd0, bus1.err}, 32'h0);
    req(1'b0, 32'h0000_0010, 32'd0, 4'd0, 1, 32'hDEAD_BEEF, 1'b1, "oor_low");
    chk("low_err_addr", bus1.err_addr, 32'h0000_0010);

    rd(1'b0, BASE + 32'h800, "b2b_rd0");
    wr(1'b0, BASE + 32'hC, 32'hC0DE_0C0C, 4'hF, "b2b_wr");
    rd(1'b0, BASE + 32'hC, "b2b_rd1");

    wr(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, "rl3_wr");
    rd(1'b1, 32'h10, "rl3_rd");
    wr(1'b1, 32'h14, 32'h0BAD_F00D, 4'b1001, "rl3_wr2");
    rd(1'b1, 32'h14, "rl3_rd2");
    rd(1'b1, 32'h10, "rl3_rd3");
    t_sel = 1'b0;

    // Reset in ACCESS: csb must release without a clock edge.
    t_addr = BASE + 32'h4; t_wstrb = 4'd0; t_valid = 1'b1;
    exp_csb++;
    tick();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_access_csb", 32'(bus1.sram_csb), 32'h3);
    chk("rst_access_ready", 32'(bus1.mem_ready), 32'h0);
    t_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Reset in WAIT: the pending read must never complete.
    t_addr = BASE + 32'h4; t_wstrb = 4'd0; t_valid = 1'b1;
    exp_csb++;
    tick(); tick();
    #1 reset = 1'b1;
    #1;
    chk("rst_wait_csb", 32'(bus1.sram_csb), 32'h3);
    chk("rst_wait_ready", 32'(bus1.mem_ready), 32'h0);
    t_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("rst_wait_rdata", bus1.mem_rdata, 32'h0);

    chk("ready_pulses", 32'(rdy1_cnt + rdy3_cnt), 32'(exp_rdy));
    chk("csb_low_cycles", 32'(csb1_cnt + csb3_cnt), 32'(exp_csb));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
